// File: rtl/dualmem_pkg.sv
// Shared width/latency derivations for the asymmetric dual-port memory.
package dualmem_pkg;

    localparam int COLL_CNT_W = 16;

    function automatic int ww_f(input int nw, input int ratio);
        return nw * ratio;
    endfunction

    function automatic int abw_f(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int aaw_f(input int depth, input int ratio);
        return $clog2(depth) + $clog2(ratio);
    endfunction

    function automatic int lat_f(input int out_reg);
        return 1 + ((out_reg != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/dualmem_asym_if.sv
// Port A (narrow) / port B (wide) access bus plus collision status.
interface dualmem_asym_if
    import dualmem_pkg::*;
#(
    parameter int NW    = 16,
    parameter int RATIO = 4,
    parameter int DEPTH = 2048
);
    localparam int WW  = ww_f(NW, RATIO);
    localparam int ABW = abw_f(DEPTH);
    localparam int AAW = aaw_f(DEPTH, RATIO);

    logic                  ena;
    logic [NW/8-1:0]       wea;
    logic [AAW-1:0]        addra;
    logic [NW-1:0]         dina;
    logic [NW-1:0]         douta;
    logic                  douta_vld;
    logic                  enb;
    logic [WW/8-1:0]       web;
    logic [ABW-1:0]        addrb;
    logic [WW-1:0]         dinb;
    logic [WW-1:0]         doutb;
    logic                  doutb_vld;
    logic                  coll;
    logic [COLL_CNT_W-1:0] coll_cnt;
    logic                  coll_clr;

    modport master (
        output ena, wea, addra, dina, enb, web, addrb, dinb, coll_clr,
        input  douta, douta_vld, doutb, doutb_vld, coll, coll_cnt
    );

    modport slave (
        input  ena, wea, addra, dina, enb, web, addrb, dinb, coll_clr,
        output douta, douta_vld, doutb, doutb_vld, coll, coll_cnt
    );

endinterface

// File: rtl/dualmem_bank.sv
// True dual-port byte-write storage, RATIO lanes of NW bits, registered read.
module dualmem_bank
    import dualmem_pkg::*;
#(
    parameter  int NW          = 16,
    parameter  int RATIO       = 4,
    parameter  int DEPTH       = 2048,
    parameter  int WRITE_FIRST = 0,
    localparam int WW          = ww_f(NW, RATIO),
    localparam int ABW         = abw_f(DEPTH),
    localparam int NB          = WW / 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en_a,
    input  logic [NB-1:0]  we_a,
    input  logic [ABW-1:0] addr_a,
    input  logic [WW-1:0]  din_a,
    output logic [WW-1:0]  q_a,
    input  logic           en_b,
    input  logic [NB-1:0]  we_b,
    input  logic [ABW-1:0] addr_b,
    input  logic [WW-1:0]  din_b,
    output logic [WW-1:0]  q_b
);
    localparam int NBL = NW / 8;

    logic same;
    assign same = (addr_a == addr_b);

    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        logic [NW-1:0]  mem [DEPTH];
        logic [NBL-1:0] wa, wb;
        logic [NW-1:0]  da, db, ra, rb, qa_l, qb_l;

        assign wa = en_a ? we_a[l*NBL +: NBL] : '0;
        assign wb = en_b ? we_b[l*NBL +: NBL] : '0;
        assign da = din_a[l*NW +: NW];
        assign db = din_b[l*NW +: NW];

        // Port B is written last so it owns bytes both ports write.
        always_ff @(posedge clk) begin
            for (int i = 0; i < NBL; i++) begin
                if (wa[i]) mem[addr_a][8*i +: 8] <= da[8*i +: 8];
                if (wb[i]) mem[addr_b][8*i +: 8] <= db[8*i +: 8];
            end
        end

        always_comb begin
            ra = mem[addr_a];
            rb = mem[addr_b];
            if (WRITE_FIRST != 0) begin
                for (int i = 0; i < NBL; i++) begin
                    if (wb[i] && same) ra[8*i +: 8] = db[8*i +: 8];
                    else if (wa[i])    ra[8*i +: 8] = da[8*i +: 8];
                    if (wb[i])              rb[8*i +: 8] = db[8*i +: 8];
                    else if (wa[i] && same) rb[8*i +: 8] = da[8*i +: 8];
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                qa_l <= '0;
                qb_l <= '0;
            end else begin
                if (en_a) qa_l <= ra;
                if (en_b) qb_l <= rb;
            end
        end

        assign q_a[l*NW +: NW] = qa_l;
        assign q_b[l*NW +: NW] = qb_l;
    end

endmodule

// File: rtl/dualmem_asym.sv
// Asymmetric dual-port memory: narrow port A, wide port B, collision tracking.
module dualmem_asym
    import dualmem_pkg::*;
#(
    parameter int NW          = 16,
    parameter int RATIO       = 4,
    parameter int DEPTH       = 2048,
    parameter int OUT_REG     = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic          clk,
    input  logic          rstn,
    dualmem_asym_if.slave bus
);
    localparam int WW  = ww_f(NW, RATIO);
    localparam int ABW = abw_f(DEPTH);
    localparam int AAW = aaw_f(DEPTH, RATIO);
    localparam int LW  = $clog2(RATIO);
    localparam int LNW = (LW > 0) ? LW : 1;
    localparam int LAT = lat_f(OUT_REG);
    localparam int NBA = NW / 8;
    localparam int NB  = WW / 8;

    logic [ABW-1:0]        word_a;
    logic [LNW-1:0]        lane_a, lane_q;
    logic [NB-1:0]         we_a_w;
    logic [WW-1:0]         q_a, q_b;
    logic [NW-1:0]         sel_a;
    logic [LAT:1]          vld_pipe_a, vld_pipe_b;
    logic                  coll_c, coll_q;
    logic [COLL_CNT_W-1:0] coll_cnt_q;

    assign word_a = ABW'(bus.addra >> LW);
    assign lane_a = LNW'(bus.addra & AAW'(RATIO - 1));
    // Narrow byte enables land on the addressed lane of the wide word.
    assign we_a_w = NB'(bus.wea) << (int'(lane_a) * NBA);

    dualmem_bank #(
        .NW(NW), .RATIO(RATIO), .DEPTH(DEPTH), .WRITE_FIRST(WRITE_FIRST)
    ) u_bank (
        .clk    (clk),
        .rstn   (rstn),
        .en_a   (bus.ena),
        .we_a   (we_a_w),
        .addr_a (word_a),
        .din_a  ({RATIO{bus.dina}}),
        .q_a    (q_a),
        .en_b   (bus.enb),
        .we_b   (bus.web),
        .addr_b (bus.addrb),
        .din_b  (bus.dinb),
        .q_b    (q_b)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe_a <= '0;
            vld_pipe_b <= '0;
            lane_q     <= '0;
        end else begin
            vld_pipe_a[1] <= bus.ena;
            vld_pipe_b[1] <= bus.enb;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe_a[i] <= vld_pipe_a[i-1];
                vld_pipe_b[i] <= vld_pipe_b[i-1];
            end
            if (bus.ena) lane_q <= lane_a;
        end
    end

    // Lane is picked alongside the bank's read register, so it tracks its word.
    assign sel_a = q_a[int'(lane_q)*NW +: NW];

    if (OUT_REG != 0) begin : g_oreg
        logic [NW-1:0] douta_q;
        logic [WW-1:0] doutb_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                douta_q <= '0;
                doutb_q <= '0;
            end else begin
                if (vld_pipe_a[1]) douta_q <= sel_a;
                if (vld_pipe_b[1]) doutb_q <= q_b;
            end
        end
        assign bus.douta = douta_q;
        assign bus.doutb = doutb_q;
    end else begin : g_noreg
        assign bus.douta = sel_a;
        assign bus.doutb = q_b;
    end

    assign bus.douta_vld = vld_pipe_a[LAT];
    assign bus.doutb_vld = vld_pipe_b[LAT];

    assign coll_c = bus.ena && bus.enb && (word_a == bus.addrb) &&
                    ((|bus.wea) || (|bus.web));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q <= coll_c;
            if (bus.coll_clr)
                coll_cnt_q <= '0;
            else if (coll_c && (coll_cnt_q != '1))
                coll_cnt_q <= coll_cnt_q + 1'b1;
        end
    end

    assign bus.coll     = coll_q;
    assign bus.coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_dualmem_asym.sv
// Scoreboard bench: read-first and write-first instances share one stimulus stream.
module tb_dualmem_asym;
    import dualmem_pkg::*;

    localparam int NW = 16, RATIO = 4, DEPTH = 2048;

    typedef struct {
        logic [63:0] v;
        bit          c;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dualmem_asym_if #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH)) if_rf ();
    dualmem_asym_if #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH)) if_wf ();

    assign if_wf.ena      = if_rf.ena;
    assign if_wf.wea      = if_rf.wea;
    assign if_wf.addra    = if_rf.addra;
    assign if_wf.dina     = if_rf.dina;
    assign if_wf.enb      = if_rf.enb;
    assign if_wf.web      = if_rf.web;
    assign if_wf.addrb    = if_rf.addrb;
    assign if_wf.dinb     = if_rf.dinb;
    assign if_wf.coll_clr = if_rf.coll_clr;

    dualmem_asym #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH), .OUT_REG(1), .WRITE_FIRST(0))
        u_rf (.clk(clk), .rstn(rstn), .bus(if_rf.slave));
    dualmem_asym #(.NW(NW), .RATIO(RATIO), .DEPTH(DEPTH), .OUT_REG(1), .WRITE_FIRST(1))
        u_wf (.clk(clk), .rstn(rstn), .bus(if_wf.slave));

    exp_t qa_rf[$], qa_wf[$], qb_rf[$], qb_wf[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got valid output expected none", nm);
    endtask

    // Monitor: pop one expectation per valid strobe on each port of each instance.
    always @(negedge clk) begin
        if (rstn) begin
            if (if_rf.douta_vld) begin
                if (qa_rf.size() == 0) unexp("rf.douta");
                else begin mon_e = qa_rf.pop_front(); if (mon_e.c) chk("rf.douta", 64'(if_rf.douta), mon_e.v); end
            end
            if (if_wf.douta_vld) begin
                if (qa_wf.size() == 0) unexp("wf.douta");
                else begin mon_e = qa_wf.pop_front(); if (mon_e.c) chk("wf.douta", 64'(if_wf.douta), mon_e.v); end
            end
            if (if_rf.doutb_vld) begin
                if (qb_rf.size() == 0) unexp("rf.doutb");
                else begin mon_e = qb_rf.pop_front(); if (mon_e.c) chk("rf.doutb", if_rf.doutb, mon_e.v); end
            end
            if (if_wf.doutb_vld) begin
                if (qb_wf.size() == 0) unexp("wf.doutb");
                else begin mon_e = qb_wf.pop_front(); if (mon_e.c) chk("wf.doutb", if_wf.doutb, mon_e.v); end
            end
        end
    end

    task automatic set_a(input int addr, input logic [1:0] we, input logic [15:0] din,
                         input logic [15:0] e_rf, input bit c_rf,
                         input logic [15:0] e_wf, input bit c_wf);
        if_rf.ena   = 1'b1;
        if_rf.wea   = we;
        if_rf.addra = 13'(addr);
        if_rf.dina  = din;
        qa_rf.push_back('{v: 64'(e_rf), c: c_rf});
        qa_wf.push_back('{v: 64'(e_wf), c: c_wf});
    endtask

    task automatic set_b(input int addr, input logic [7:0] we, input logic [63:0] din,
                         input logic [63:0] e_rf, input bit c_rf,
                         input logic [63:0] e_wf, input bit c_wf);
        if_rf.enb   = 1'b1;
        if_rf.web   = we;
        if_rf.addrb = 11'(addr);
        if_rf.dinb  = din;
        qb_rf.push_back('{v: e_rf, c: c_rf});
        qb_wf.push_back('{v: e_wf, c: c_wf});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if_rf.ena      = 1'b0;
        if_rf.wea      = '0;
        if_rf.enb      = 1'b0;
        if_rf.web      = '0;
        if_rf.coll_clr = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 30 && (qa_rf.size() + qa_wf.size() + qb_rf.size() + qb_wf.size()) != 0; i++)
            @(posedge clk);
        #1;
        chk(nm, 64'(qa_rf.size() + qa_wf.size() + qb_rf.size() + qb_wf.size()), 64'd0);
    endtask

    initial begin
        if_rf.ena = 1'b0; if_rf.wea = '0; if_rf.addra = '0; if_rf.dina = '0;
        if_rf.enb = 1'b0; if_rf.web = '0; if_rf.addrb = '0; if_rf.dinb = '0;
        if_rf.coll_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst douta",     64'(if_rf.douta), 64'd0);
        chk("rst doutb",     if_rf.doutb, 64'd0);
        chk("rst douta_vld", 64'(if_rf.douta_vld), 64'd0);
        chk("rst doutb_vld", 64'(if_rf.doutb_vld), 64'd0);
        chk("rst coll",      64'(if_rf.coll), 64'd0);
        chk("rst coll_cnt",  64'(if_rf.coll_cnt), 64'd0);
        chk("rst wf douta",  64'(if_wf.douta), 64'd0);
        chk("rst wf coll_cnt", 64'(if_wf.coll_cnt), 64'd0);
        rstn = 1'b1;
        tick();

        // Wide write, then narrow lane reads back-to-back.
        set_b(5, 8'hFF, 64'h4444_3333_2222_1111, 64'd0, 0, 64'h4444_3333_2222_1111, 1); tick();
        set_a(20, 2'b00, 16'h0, 16'h1111, 1, 16'h1111, 1); tick();
        set_a(21, 2'b00, 16'h0, 16'h2222, 1, 16'h2222, 1); tick();
        set_a(22, 2'b00, 16'h0, 16'h3333, 1, 16'h3333, 1); tick();
        set_a(23, 2'b00, 16'h0, 16'h4444, 1, 16'h4444, 1); tick();

        // Narrow partial-byte write seen through the wide port.
        set_b(2, 8'hFF, 64'd0, 64'd0, 0, 64'd0, 1); tick();
        set_a(9, 2'b10, 16'hBEEF, 16'h0000, 1, 16'hBE00, 1); tick();
        set_b(2, 8'h00, 64'd0, 64'h0000_0000_BE00_0000, 1, 64'h0000_0000_BE00_0000, 1); tick();

        // Write-write collision: port B owns overlapping bytes.
        chk("coll_cnt pre", 64'(if_rf.coll_cnt), 64'd0);
        set_a(0, 2'b11, 16'hAAAA, 16'h0, 0, 16'h5555, 1);
        set_b(0, 8'hFF, 64'h5555_5555_5555_5555, 64'd0, 0, 64'h5555_5555_5555_5555, 1);
        tick();
        chk("coll pulse rf", 64'(if_rf.coll), 64'd1);
        chk("coll pulse wf", 64'(if_wf.coll), 64'd1);
        chk("coll_cnt 1",    64'(if_rf.coll_cnt), 64'd1);
        set_a(0, 2'b00, 16'h0, 16'h5555, 1, 16'h5555, 1);
        set_b(0, 8'h00, 64'd0, 64'h5555_5555_5555_5555, 1, 64'h5555_5555_5555_5555, 1);
        tick();
        chk("coll one cycle", 64'(if_rf.coll), 64'd0);

        // Cross-port read of a word being written: read-first vs write-first.
        set_b(1, 8'hFF, 64'd0, 64'd0, 0, 64'd0, 1); tick();
        set_a(4, 2'b00, 16'h0, 16'h0000, 1, 16'h0007, 1);
        set_b(1, 8'hFF, 64'h7, 64'd0, 1, 64'h7, 1);
        tick();
        chk("coll_cnt 2 rf", 64'(if_rf.coll_cnt), 64'd2);
        chk("coll_cnt 2 wf", 64'(if_wf.coll_cnt), 64'd2);
        set_b(1, 8'h00, 64'd0, 64'h7, 1, 64'h7, 1); tick();

        // Saturation near the top of the counter.
        force u_rf.coll_cnt_q = 16'hFFFE;
        force u_wf.coll_cnt_q = 16'hFFFE;
        #1;
        release u_rf.coll_cnt_q;
        release u_wf.coll_cnt_q;
        set_a(8, 2'b11, 16'h1234, 16'h0000, 1, 16'h1234, 1);
        set_b(2, 8'h00, 64'd0, 64'h0000_0000_BE00_0000, 1, 64'h0000_0000_BE00_1234, 1);
        tick();
        chk("coll_cnt ffff", 64'(if_rf.coll_cnt), 64'hFFFF);
        set_a(8, 2'b00, 16'h0, 16'h1234, 1, 16'h12FF, 1);
        set_b(2, 8'h01, 64'hFF, 64'h0000_0000_BE00_1234, 1, 64'h0000_0000_BE00_12FF, 1);
        tick();
        chk("coll_cnt sat rf", 64'(if_rf.coll_cnt), 64'hFFFF);
        chk("coll_cnt sat wf", 64'(if_wf.coll_cnt), 64'hFFFF);

        // Clear wins over a simultaneous collision.
        set_a(8, 2'b00, 16'h0, 16'h12FF, 1, 16'hABFF, 1);
        set_b(2, 8'h02, 64'h0000_0000_0000_AB00, 64'h0000_0000_BE00_12FF, 1, 64'h0000_0000_BE00_ABFF, 1);
        if_rf.coll_clr = 1'b1;
        tick();
        chk("coll_clr cnt", 64'(if_rf.coll_cnt), 64'd0);
        chk("coll_clr coll", 64'(if_rf.coll), 64'd1);

        // Zero byte enables on both ports: no write, no collision.
        set_a(8, 2'b00, 16'hFFFF, 16'hABFF, 1, 16'hABFF, 1);
        set_b(2, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_BE00_ABFF, 1, 64'h0000_0000_BE00_ABFF, 1);
        tick();
        chk("no coll zero be", 64'(if_rf.coll), 64'd0);
        set_b(2, 8'h00, 64'd0, 64'h0000_0000_BE00_ABFF, 1, 64'h0000_0000_BE00_ABFF, 1); tick();
        chk("coll_cnt held 0", 64'(if_rf.coll_cnt), 64'd0);

        // Reset with a read in flight: dropped, memory kept.
        set_b(3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 64'h0123_4567_89AB_CDEF, 1); tick();
        drain("drain pre-reset");
        if_rf.ena = 1'b1; if_rf.wea = '0; if_rf.addra = 13'd12;
        tick();
        rstn = 1'b0;
        #1;
        chk("mid rst douta_vld", 64'(if_rf.douta_vld), 64'd0);
        chk("mid rst douta",     64'(if_rf.douta), 64'd0);
        chk("mid rst doutb",     if_rf.doutb, 64'd0);
        chk("mid rst wf douta",  64'(if_wf.douta), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        set_a(12, 2'b00, 16'h0, 16'hCDEF, 1, 16'hCDEF, 1); tick();
        set_a(15, 2'b00, 16'h0, 16'h0123, 1, 16'h0123, 1);
        set_b(3, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 1);
        tick();
        drain("drain end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
